sample_stream_checker: RTL
==========================

Name: sample_stream_checker

Overview:
- Receive-side checker for the 16-bit sample word stream: bits [15:10] sequence number (0..62, each value held for 65536 words, then wraps to 0); bits [9:0] ADC sample or, in test mode, a counting pattern 0..1020 that wraps to 0.
- Acquires lock to the sequence-number framing and flags sequence discontinuities.
- In test mode, checks the test pattern word by word.
- Sits at the consumer end of the sample path, e.g. loopback verification or a host-side bridge, and re-emits the 10-bit samples.

Parameters:
- SEQ_MODULUS, 63: number of distinct sequence values; the value after SEQ_MODULUS-1 is 0.
- BLOCK_LOG2, 16: log2 of words per sequence value.
- TEST_MODULUS, 1021: test pattern period; the value after TEST_MODULUS-1 is 0.

Ports:
- clock, input, 1: system clock; all logic is on the rising edge.
- nReset, input, 1: asynchronous active-low reset.
- dataIn, input, 16: received word.
- dataValid, input, 1: dataIn is valid this cycle; words are consumed only when high.
- testModeFlag, input, 1: enables test pattern checking.
- clearCounters, input, 1: synchronous clear of both error counters.
- sampleOut, output, 10: registered dataIn[9:0].
- sampleValid, output, 1: registered dataValid.
- locked, output, 1: high in LOCKED state.
- seqError, output, 1: one-cycle pulse on a sequence mismatch.
- dataError, output, 1: one-cycle pulse on a test pattern mismatch.
- seqErrorCount, output, 16: saturating count of sequence mismatches.
- dataErrorCount, output, 16: saturating count of test pattern mismatches.

Behaviour:
- Reset: all outputs 0; state HUNT; internal prevSeq, expSeq, posCount (BLOCK_LOG2 bits), expTest and testSeeded all 0.
- Latency: every output updates on the clock edge that consumes the word (one cycle after dataIn/dataValid are presented). Nothing changes on cycles where dataValid=0, except the clearCounters and testModeFlag effects below.
- next(s) = (s == SEQ_MODULUS-1) ? 0 : s+1.
- HUNT: on a valid word, prevSeq := dataIn[15:10]; go to ALIGN.
- ALIGN, on a valid word with seq = dataIn[15:10]:
  - seq == prevSeq: stay in ALIGN.
  - seq == next(prevSeq): a block boundary is found. expSeq := seq, posCount := 1, go to LOCKED.
  - any other seq: prevSeq := seq, stay in ALIGN.
  - No errors are flagged in HUNT or ALIGN.
- LOCKED, on a valid word:
  - seq != expSeq: pulse seqError, increment seqErrorCount, go to HUNT.
  - seq == expSeq: posCount += 1, wrapping to 0 at 2^BLOCK_LOG2. When posCount wraps (i.e. it was all-ones), expSeq := next(expSeq).
  - A word at block position 0 must therefore carry the incremented sequence value.
  - Wrap case: seq 62 at position 65535, then seq 0.
- Test pattern check, applied in any state when testModeFlag=1 and dataValid=1; d = dataIn[9:0]:
  - testSeeded=0: expTest := tnext(d); testSeeded := 1; no check on this word.
  - testSeeded=1, d == expTest: expTest := tnext(d).
  - testSeeded=1, d != expTest: pulse dataError, increment dataErrorCount, expTest := tnext(d) (reseed).
  - Consequence of reseeding: a dropped word costs 1 error; a single corrupted word costs 2 errors.
  - tnext(d) = (d >= TEST_MODULUS-1) ? 0 : d+1. A value d > TEST_MODULUS-1 is always a mismatch.
  - testModeFlag=0 clears testSeeded the next edge; no data checking while it is low.
- Counters saturate at 16'hFFFF.
- clearCounters=1 zeroes both counters that edge and overrides a same-cycle increment. The seqError/dataError pulses still assert.
- A seqError and a dataError on the same word are independent; both pulse.
- Asynchronous reset mid-stream returns to HUNT immediately. Re-lock then needs a fresh block boundary, up to 65536 + 2 words.
- sampleOut/sampleValid pass data in every state, regardless of lock.

Test Plan:
- Clean stream, test mode, starting at seq 5, position 65530, test value 100:
  - locked rises on the edge consuming the seq-6 position-0 word (7th word).
  - Run 3×65536 words: seqErrorCount=0, dataErrorCount=0.
  - sampleOut equals dataIn[9:0] one cycle later.
- Sequence wrap: lock on seq 61, stream through seq 62 then seq 0 at the boundary -> stays locked, no seqError.
  - Same stream with seq 63 injected instead of 0 -> seqError pulses once, count=1, locked=0 next cycle.
- Dropped word in the test pattern (…499, 500, 502, 503…) -> exactly one dataError on 502, dataErrorCount=1.
  - Corrupt 500→0x3FF -> count=2. Pattern 1019, 1020, 0 -> no error.
- dataValid gaps: alternate dataValid 1/0 across a block boundary -> lock and checks are identical to the gapless case; sampleValid mirrors dataValid delayed one cycle.
- Counter saturation/clear:
  - Force 65540 sequence errors -> seqErrorCount holds 0xFFFF.
  - Assert clearCounters on the same edge as an error -> counter reads 0 and seqError still pulses.
- Reset mid-lock: assert nReset low for one cycle at position 30000 -> all outputs 0 asynchronously; re-lock at the next boundary, no spurious errors.

Source files
------------

// File: rtl/sample_stream_checker.sv
// Receive-side checker for the sequence-numbered 16-bit sample word stream.
// Ports: clock/nReset; dataIn/dataValid word input; testModeFlag, clearCounters
// controls; sampleOut/sampleValid re-emitted samples; locked, seqError,
// dataError status; seqErrorCount/dataErrorCount saturating error counters.
module sample_stream_checker #(
  parameter int          SEQ_MODULUS  = 63,
  parameter int          BLOCK_LOG2   = 16,
  parameter int          TEST_MODULUS = 1021,
  parameter logic [15:0] CNT_MAX      = 16'hFFFF
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [15:0] dataIn,
  input  logic        dataValid,
  input  logic        testModeFlag,
  input  logic        clearCounters,
  output logic [9:0]  sampleOut,
  output logic        sampleValid,
  output logic        locked,
  output logic        seqError,
  output logic        dataError,
  output logic [15:0] seqErrorCount,
  output logic [15:0] dataErrorCount
);

  localparam logic [5:0] SEQ_LAST  = 6'(SEQ_MODULUS - 1);
  localparam logic [9:0] TEST_LAST = 10'(TEST_MODULUS - 1);
  localparam logic [BLOCK_LOG2-1:0] POS_ONE = BLOCK_LOG2'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [5:0] seqNext(input logic [5:0] s);
    return (s == SEQ_LAST) ? 6'd0 : s + 6'd1;
  endfunction

  function automatic logic [9:0] testNext(input logic [9:0] d);
    return (d >= TEST_LAST) ? 10'd0 : d + 10'd1;
  endfunction

  function automatic logic [15:0] cntNext(
    input logic [15:0] c,
    input logic        inc,
    input logic        clr
  );
    logic [15:0] r;
    r = c;
    if (clr) begin
      r = '0;
    end else if (inc && (c != CNT_MAX)) begin
      r = c + 16'd1;
    end
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [5:0]            prevSeq_q, prevSeq_d;
  logic [5:0]            expSeq_q, expSeq_d;
  logic [BLOCK_LOG2-1:0] posCount_q, posCount_d;
  logic [9:0]            expTest_q, expTest_d;
  logic                  testSeeded_q, testSeeded_d;
  logic [9:0]            sample_q, sample_d;
  logic                  sampleValid_q;
  logic                  seqErr_q, seqErr_d;
  logic                  dataErr_q, dataErr_d;
  logic [15:0]           seqCnt_q, seqCnt_d;
  logic [15:0]           dataCnt_q, dataCnt_d;

  logic [5:0] seq;
  logic [9:0] tval;

  assign seq  = dataIn[15:10];
  assign tval = dataIn[9:0];

  // State register
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (dataValid) begin
      case (state_q)
        HUNT: begin
          state_d = ALIGN;
        end
        ALIGN: begin
          if (seq != prevSeq_q &&
              seq == seqNext(prevSeq_q)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (seq != expSeq_q) begin
            state_d = HUNT;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Sequence tracking datapath
  always_comb begin
    prevSeq_d  = prevSeq_q;
    expSeq_d   = expSeq_q;
    posCount_d = posCount_q;
    seqErr_d   = 1'b0;
    if (dataValid) begin
      case (state_q)
        HUNT: begin
          prevSeq_d = seq;
        end
        ALIGN: begin
          if (seq == prevSeq_q) begin
            prevSeq_d = prevSeq_q;
          end else if (seq == seqNext(prevSeq_q)) begin
            expSeq_d   = seq;
            posCount_d = POS_ONE;
          end else begin
            prevSeq_d = seq;
          end
        end
        LOCKED: begin
          if (seq != expSeq_q) begin
            seqErr_d = 1'b1;
          end else begin
            posCount_d = posCount_q + POS_ONE;
            // Last word of a block: the next word opens the next block.
            if (&posCount_q) begin
              expSeq_d = seqNext(expSeq_q);
            end
          end
        end
        default: begin
          prevSeq_d = prevSeq_q;
        end
      endcase
    end
  end

  // Test pattern checker; a mismatch reseeds from the received word
  always_comb begin
    expTest_d    = expTest_q;
    testSeeded_d = testSeeded_q;
    dataErr_d    = 1'b0;
    if (!testModeFlag) begin
      testSeeded_d = 1'b0;
    end else if (dataValid) begin
      expTest_d    = testNext(tval);
      testSeeded_d = 1'b1;
      if (testSeeded_q && (tval != expTest_q)) begin
        dataErr_d = 1'b1;
      end
    end
  end

  always_comb begin
    sample_d  = dataValid ? tval : sample_q;
    seqCnt_d  = cntNext(seqCnt_q, seqErr_d, clearCounters);
    dataCnt_d = cntNext(dataCnt_q, dataErr_d, clearCounters);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      prevSeq_q     <= '0;
      expSeq_q      <= '0;
      posCount_q    <= '0;
      expTest_q     <= '0;
      testSeeded_q  <= 1'b0;
      sample_q      <= '0;
      sampleValid_q <= 1'b0;
      seqErr_q      <= 1'b0;
      dataErr_q     <= 1'b0;
      seqCnt_q      <= '0;
      dataCnt_q     <= '0;
    end else begin
      prevSeq_q     <= prevSeq_d;
      expSeq_q      <= expSeq_d;
      posCount_q    <= posCount_d;
      expTest_q     <= expTest_d;
      testSeeded_q  <= testSeeded_d;
      sample_q      <= sample_d;
      sampleValid_q <= dataValid;
      seqErr_q      <= seqErr_d;
      dataErr_q     <= dataErr_d;
      seqCnt_q      <= seqCnt_d;
      dataCnt_q     <= dataCnt_d;
    end
  end

  assign sampleOut      = sample_q;
  assign sampleValid    = sampleValid_q;
  assign seqError       = seqErr_q;
  assign dataError      = dataErr_q;
  assign seqErrorCount  = seqCnt_q;
  assign dataErrorCount = dataCnt_q;

endmodule
